// File: rtl/exec_pipeline_pkg.sv
// Shared types for the execute pipeline: ALU operation codes, boolean and
// register-address typedefs.
package exec_pipeline_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef logic bool_t;

  localparam int REG_AW = 5;
  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/exec_pipeline_alu.sv
// Combinational ALU; arithmetic wraps modulo 2^XLEN and shifts use the low
// $clog2(XLEN) bits of operand B.
module alu
  import exec_pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t           i_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [XLEN-1:0]   o_y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  // Result select by operation
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_SRA:  o_y = $unsigned($signed(i_a) >>> w_shamt);
      ALU_SLT:  o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/exec_pipeline.sv
// Two-stage execute pipeline (ID/EX, EX/WB) with full operand forwarding,
// register file, ebreak halt handling and a retire counter.
module exec_pipeline
  import exec_pipeline_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_op_t           op,
  input  logic [AW-1:0]     dst,
  input  logic [AW-1:0]     src1,
  input  logic [AW-1:0]     src2,
  input  logic              has_immediate,
  input  logic [XLEN-1:0]   imm,
  input  logic              ebreak,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_dst,
  output logic [XLEN-1:0]   wb_data,
  output logic              halted,
  output logic [CNT_W-1:0]  retired,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  typedef logic [XLEN-1:0] word_t;

  word_t          r_regs [NREGS];
  bool_t          r_idex_valid, r_idex_ebreak;
  alu_op_t        r_idex_op;
  logic [AW-1:0]  r_idex_dst;
  word_t          r_idex_a, r_idex_b;
  bool_t          r_exwb_valid, r_exwb_ebreak;
  logic [AW-1:0]  r_exwb_dst;
  word_t          r_exwb_data;
  bool_t          r_halting, r_halted;
  logic [CNT_W-1:0] r_retired;

  word_t w_alu_y, w_src1_val, w_src2_val;
  logic  w_accept, w_wb_valid;

  alu #(.XLEN(XLEN)) u_alu (
    .i_op (r_idex_op),
    .i_a  (r_idex_a),
    .i_b  (r_idex_b),
    .o_y  (w_alu_y)
  );

  // Youngest producer wins; x0 is hard zero even if an in-flight entry targets it.
  function automatic word_t fwd(input logic [AW-1:0] src);
    if (src == '0) begin
      return '0;
    end else if (r_idex_valid && !r_idex_ebreak && (r_idex_dst == src)) begin
      return w_alu_y;
    end else if (r_exwb_valid && !r_exwb_ebreak && (r_exwb_dst == src)) begin
      return r_exwb_data;
    end else begin
      return r_regs[src];
    end
  endfunction

  assign in_ready   = rst_n & ~r_halting;
  assign w_accept   = in_valid & in_ready;
  assign w_wb_valid = r_exwb_valid & ~r_exwb_ebreak;

  // Operand selection at acceptance
  always_comb begin
    w_src1_val = fwd(src1);
    w_src2_val = '0;
    if (has_immediate) begin
      w_src2_val = imm;
    end else begin
      w_src2_val = fwd(src2);
    end
  end

  // ID/EX stage register; idle edges load a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_valid  <= 1'b0;
      r_idex_ebreak <= 1'b0;
      r_idex_op     <= ALU_ADD;
      r_idex_dst    <= '0;
      r_idex_a      <= '0;
      r_idex_b      <= '0;
    end else begin
      r_idex_valid <= w_accept;
      if (w_accept) begin
        r_idex_ebreak <= ebreak;
        r_idex_op     <= op;
        r_idex_dst    <= dst;
        r_idex_a      <= w_src1_val;
        r_idex_b      <= w_src2_val;
      end
    end
  end

  // EX/WB stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exwb_valid  <= 1'b0;
      r_exwb_ebreak <= 1'b0;
      r_exwb_dst    <= '0;
      r_exwb_data   <= '0;
    end else begin
      r_exwb_valid  <= r_idex_valid;
      r_exwb_ebreak <= r_idex_ebreak;
      r_exwb_dst    <= r_idex_dst;
      r_exwb_data   <= w_alu_y;
    end
  end

  // Halt tracking and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halting <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_halting <= r_halting | (w_accept & ebreak);
      r_halted  <= r_halted | (r_exwb_valid & r_exwb_ebreak);
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, w_wb_valid};
    end
  end

  // Register file write-back; x0 writes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_valid && (r_exwb_dst != '0)) begin
      r_regs[r_exwb_dst] <= r_exwb_data;
    end
  end

  assign wb_valid = w_wb_valid;
  assign wb_dst   = r_exwb_dst;
  assign wb_data  = r_exwb_data;
  assign halted   = r_halted;
  assign retired  = r_retired;
  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_exec_pipeline.sv
// Randomized and directed bench for exec_pipeline against an in-order
// architectural model with a fixed two-edge retire latency.
module tb_exec_pipeline;
  import exec_pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, has_imm, ebreak, wb_valid, halted;
  alu_op_t     op;
  logic [4:0]  dst, src1, src2, wb_dst, dbg_addr;
  logic [31:0] imm, wb_data, retired, dbg_data;

  logic        h_in_valid, h_in_ready, h_has_imm, h_ebreak, h_wb_valid, h_halted;
  alu_op_t     h_op;
  logic [4:0]  h_dst, h_src1, h_src2, h_wb_dst, h_dbg_addr;
  logic [15:0] h_imm, h_wb_data, h_dbg_data;
  logic [31:0] h_retired;

  exec_pipeline dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dst(dst), .src1(src1), .src2(src2), .has_immediate(has_imm), .imm(imm),
    .ebreak(ebreak), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .halted(halted), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  exec_pipeline #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
    .dst(h_dst), .src1(h_src1), .src2(h_src2), .has_immediate(h_has_imm), .imm(h_imm),
    .ebreak(h_ebreak), .wb_valid(h_wb_valid), .wb_dst(h_wb_dst), .wb_data(h_wb_data),
    .halted(h_halted), .retired(h_retired), .dbg_addr(h_dbg_addr), .dbg_data(h_dbg_data)
  );

  typedef struct { bit v; bit eb; bit [4:0] dst; bit [31:0] data; } ent_t;
  typedef struct { bit v; bit [4:0] d; bit [31:0] x; } obs_t;

  ent_t      pipe [2];
  bit [31:0] m_arch [32];
  bit [31:0] m_comm [32];
  bit        m_halting, m_halted;
  bit [31:0] m_retired;
  obs_t      hist [$];
  int        n_vec = 0;
  int        n_err = 0;

  function automatic bit [31:0] model_alu(alu_op_t o, bit [31:0] a, bit [31:0] b);
    case (o)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{1'b0, 1'b0, 5'd0, 32'd0};
    for (int i = 0; i < 32; i++) begin
      m_arch[i] = 32'd0;
      m_comm[i] = 32'd0;
    end
    m_halting = 1'b0;
    m_halted  = 1'b0;
    m_retired = 32'd0;
  endtask

  task automatic check_all();
    bit ev;
    ev = pipe[1].v && !pipe[1].eb;
    chk("wb_valid", 32'(wb_valid), 32'(ev));
    if (ev) begin
      chk("wb_dst", 32'(wb_dst), 32'(pipe[1].dst));
      chk("wb_data", wb_data, pipe[1].data);
    end
    chk("in_ready", 32'(in_ready), 32'(!m_halting));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("retired", retired, m_retired);
    chk("dbg_data", dbg_data, m_comm[dbg_addr]);
    hist.push_back('{wb_valid, wb_dst, wb_data});
  endtask

  // Called at a falling edge with inputs set; advances one rising edge.
  task automatic step();
    ent_t e;
    bit acc;
    bit [31:0] a, b;
    acc = in_valid && !m_halting;
    e = '{1'b0, 1'b0, 5'd0, 32'd0};
    if (acc) begin
      a = m_arch[src1];
      b = has_imm ? imm : m_arch[src2];
      e.v = 1'b1; e.eb = ebreak; e.dst = dst; e.data = model_alu(op, a, b);
      if (!ebreak && dst != 5'd0) m_arch[dst] = e.data;
    end
    @(posedge clk);
    if (pipe[1].v && !pipe[1].eb) begin
      m_retired++;
      if (pipe[1].dst != 5'd0) m_comm[pipe[1].dst] = pipe[1].data;
    end
    if (pipe[1].v && pipe[1].eb) m_halted = 1'b1;
    pipe[1] = pipe[0];
    pipe[0] = e;
    if (acc && ebreak) m_halting = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  task automatic issue(input bit v, input alu_op_t o, input int d, input int s1, input int s2,
                       input bit hi, input bit [31:0] im, input bit eb);
    in_valid = v; op = o; dst = 5'(d); src1 = 5'(s1); src2 = 5'(s2);
    has_imm = hi; imm = im; ebreak = eb;
    step();
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, ALU_ADD, 0, 0, 0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic dbg_lit(input string name, input int a, input bit [31:0] exp);
    dbg_addr = 5'(a);
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; h_in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", retired, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i += 3) dbg_lit("rst_reg", i, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic hissue(input alu_op_t o, input int d, input int s1, input bit [15:0] im);
    h_in_valid = 1'b1; h_op = o; h_dst = 5'(d); h_src1 = 5'(s1); h_src2 = 5'd0;
    h_has_imm = 1'b1; h_imm = im; h_ebreak = 1'b0;
    @(posedge clk);
    @(negedge clk);
    h_in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] r;
    in_valid = 1'b0; op = ALU_ADD; dst = 5'd0; src1 = 5'd0; src2 = 5'd0;
    has_imm = 1'b0; imm = 32'd0; ebreak = 1'b0; dbg_addr = 5'd0;
    h_in_valid = 1'b0; h_op = ALU_ADD; h_dst = 5'd0; h_src1 = 5'd0; h_src2 = 5'd0;
    h_has_imm = 1'b0; h_imm = 16'd0; h_ebreak = 1'b0; h_dbg_addr = 5'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 16-bit instance: wrap-around and shift-amount truncation
    chk("h_in_ready", 32'(h_in_ready), 32'd1);
    hissue(ALU_ADD, 1, 0, 16'hFFFF);
    hissue(ALU_ADD, 1, 1, 16'd1);
    hissue(ALU_ADD, 3, 0, 16'd3);
    hissue(ALU_SLL, 2, 3, 16'd17);
    repeat (3) @(negedge clk);
    h_dbg_addr = 5'd1; #1;
    chk("h_x1_wrap", 32'(h_dbg_data), 32'd0);
    h_dbg_addr = 5'd2; #1;
    chk("h_x2_sll", 32'(h_dbg_data), 32'd6);
    h_dbg_addr = 5'd3; #1;
    chk("h_x3", 32'(h_dbg_data), 32'd3);

    // Back-to-back dependent ADDIs
    hist.delete();
    issue(1'b1, ALU_ADD, 1, 0, 0, 1'b1, 32'd10, 1'b0);
    issue(1'b1, ALU_ADD, 1, 1, 0, 1'b1, 32'd40, 1'b0);
    issue(1'b1, ALU_ADD, 2, 1, 0, 1'b1, 32'd10, 1'b0);
    bubbles(3);
    chk("d23_wb1", {hist[1].v, hist[1].x[30:0]}, {1'b1, 31'd10});
    chk("d23_wb2", {hist[2].v, hist[2].x[30:0]}, {1'b1, 31'd50});
    chk("d23_wb3", {hist[3].v, hist[3].x[30:0]}, {1'b1, 31'd60});
    dbg_lit("d23_x1", 1, 32'd50);
    dbg_lit("d23_x2", 2, 32'd60);

    // EX/WB forwarding across one bubble
    issue(1'b1, ALU_ADD, 3, 2, 0, 1'b1, 32'd1, 1'b0);
    bubbles(1);
    issue(1'b1, ALU_SUB, 5, 3, 1, 1'b0, 32'd0, 1'b0);
    bubbles(3);
    dbg_lit("d24_x5", 5, 32'd11);

    // Writes to x0 are visible on wb but never stored or forwarded
    hist.delete();
    issue(1'b1, ALU_ADD, 0, 0, 0, 1'b1, 32'd7, 1'b0);
    issue(1'b1, ALU_ADD, 4, 0, 0, 1'b1, 32'd1, 1'b0);
    bubbles(3);
    chk("d25_x0_wb", {hist[1].v, 26'd0, hist[1].d}, {1'b1, 26'd0, 5'd0});
    chk("d25_x0_data", hist[1].x, 32'd7);
    dbg_lit("d25_x0", 0, 32'd0);
    dbg_lit("d25_x4", 4, 32'd1);

    // Reset with two instructions in flight
    issue(1'b1, ALU_ADD, 7, 0, 0, 1'b1, 32'd5, 1'b0);
    issue(1'b1, ALU_ADD, 8, 0, 0, 1'b1, 32'd6, 1'b0);
    do_reset();
    bubbles(3);
    dbg_lit("d27_x7", 7, 32'd0);
    dbg_lit("d27_x8", 8, 32'd0);
    chk("d27_retired", retired, 32'd0);

    // Three instructions then ebreak
    issue(1'b1, ALU_ADD, 1, 0, 0, 1'b1, 32'd1, 1'b0);
    issue(1'b1, ALU_ADD, 2, 1, 0, 1'b1, 32'd2, 1'b0);
    issue(1'b1, ALU_ADD, 3, 2, 0, 1'b1, 32'd3, 1'b0);
    issue(1'b1, ALU_ADD, 0, 0, 0, 1'b0, 32'd0, 1'b1);
    chk("d26_ready", 32'(in_ready), 32'd0);
    issue(1'b1, ALU_ADD, 6, 0, 0, 1'b1, 32'd99, 1'b0);
    chk("d26_halt_k1", 32'(halted), 32'd0);
    issue(1'b1, ALU_ADD, 6, 0, 0, 1'b1, 32'd99, 1'b0);
    chk("d26_halt_k2", 32'(halted), 32'd1);
    chk("d26_retired", retired, 32'd3);
    bubbles(2);
    dbg_lit("d26_x3", 3, 32'd6);
    dbg_lit("d26_x6", 6, 32'd0);

    // Randomized runs, each ending with an occasional ebreak
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        r = $urandom;
        if (r[0]) r = {{20{r[11]}}, r[11:0]};
        dbg_addr = 5'($urandom_range(0, 7));
        issue(($urandom % 5) != 0, alu_op_t'($urandom_range(0, 9)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              1'($urandom), r, (c > 300) && (($urandom % 100) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exec_pipeline.md
EXEC_PIPELINE -- requirements
Module: exec_pipeline

Interface
REQ-001 Parameter XLEN, default 32, SHALL set datapath width in bits.
REQ-002 Parameter NREGS, default 32, SHALL set register count; address width = $clog2(NREGS).
REQ-003 Parameter CNT_W, default 32, SHALL set retire-counter width.
REQ-004 Ports SHALL be:
  clk  in  1  sole clock; all state changes on rising edge
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  decoded instruction present
  in_ready  out  1  pipeline accepts instruction this cycle
  op  in  AluOp  ALU operation
  dst, src1, src2  in  addr  register addresses
  has_immediate  in  1  ALU operand B = imm instead of src2 value
  imm  in  XLEN  sign-extended immediate
  ebreak  in  1  halt request; no register write
  wb_valid  out  1  EX/WB stage holds a retiring instruction
  wb_dst  out  addr  retiring destination
  wb_data  out  XLEN  retiring result
  halted  out  1  sticky halt flag
  retired  out  CNT_W  count of retired non-ebreak instructions
  dbg_addr  in  addr  debug read address
  dbg_data  out  XLEN  combinational register-file read of dbg_addr

Function
REQ-005 A transfer SHALL occur on a rising edge where in_valid && in_ready.
REQ-006 Two pipeline registers SHALL exist: ID/EX (operands, op, dst, ebreak, valid) and EX/WB (result, dst, ebreak, valid).
REQ-007 Instruction accepted at edge k SHALL occupy ID/EX during cycle k..k+1, EX/WB during k+1..k+2, and write the register file at edge k+2.
REQ-008 wb_valid/wb_dst/wb_data SHALL reflect EX/WB; wb_valid SHALL be 0 for ebreak entries.
REQ-009 Operand selection at acceptance, priority order: src==0 -> 0; ID/EX valid, non-ebreak, dst==src -> live ALU output; EX/WB valid, non-ebreak, dst==src -> wb_data; else register file.
REQ-010 Back-to-back dependent instructions SHALL never stall; in_ready SHALL be 1 whenever not halting/halted.
REQ-011 Writes to register 0 SHALL be discarded; register 0 SHALL always read 0 (including dbg_data and forwarding).
REQ-012 ALU arithmetic SHALL be modulo 2^XLEN; shift amounts SHALL use the low $clog2(XLEN) bits of operand B.
REQ-013 Edge with in_valid=0 SHALL insert a bubble (valid=0) into ID/EX.
REQ-014 Accepting ebreak SHALL drive in_ready=0 from the following cycle onward; no further instruction SHALL be accepted.
REQ-015 halted SHALL rise on the edge at which the ebreak entry leaves EX/WB (edge k+2) and stay 1 until reset; older instructions SHALL have retired by then.
REQ-016 retired SHALL increment by 1 on every edge where wb_valid=1; wrap at 2^CNT_W.
REQ-017 dbg_data SHALL show the register-file content (not forwarded values).

Reset
REQ-018 rst_n=0 SHALL immediately clear: all valid bits, halting state, halted, retired, every register to 0.
REQ-019 During reset in_ready SHALL be 0; it SHALL be 1 in the first cycle after rst_n deasserts.
REQ-020 Reset mid-operation SHALL discard all in-flight instructions without register writes.

Structure
REQ-021 AluOp, Bool and register-address typedefs SHALL live in the shared types package; XLEN-sized word type SHALL be derived from the parameter locally.
REQ-022 The existing ALU SHALL be instantiated as sub-module alu, parametrised by XLEN; register array, forwarding and control SHALL be local.

Verification
REQ-023 ADDI x1,x0,10; ADDI x1,x1,40; ADDI x2,x1,10 back-to-back -> wb_data 10,50,60 on consecutive cycles; dbg x1=50, x2=60.
REQ-024 ADDI x3,x2,1 then one bubble then SUB x5,x3,x1 (x1=50,x2=60) -> x5=11 via EX/WB forwarding.
REQ-025 ADDI x0,x0,7 then ADDI x4,x0,1 -> wb_valid pulse with wb_dst=0, x0 reads 0, x4=1.
REQ-026 Three instructions then EBREAK -> in_ready low the cycle after EBREAK accepted, halted high 2 edges after acceptance, retired=3, later in_valid ignored.
REQ-027 rst_n pulsed low while two instructions in flight -> wb_valid=0, retired=0, all registers 0, in_ready=1 after release.
REQ-028 With XLEN=16: ADDI x1,x0,-1; ADDI x1,x1,1 -> x1=0 (wrap); SLL by imm 17 -> shift by 1.
